// File: rtl/fir_pkg.sv
// Shared definitions for the FIR coefficient loader: default sizes, coefficient types
// and the loader FSM state encoding.
package fir_pkg;

    localparam int DEF_NUM_TAPS    = 8;
    localparam int DEF_COEFF_WIDTH = 16;

    typedef logic [DEF_COEFF_WIDTH-1:0]              coeff_t;
    typedef logic [DEF_NUM_TAPS*DEF_COEFF_WIDTH-1:0] coeff_bus_t;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DRAIN,
        PENDING
    } loader_state_t;

    // Index width never drops to zero, so a single-tap filter still gets a real register.
    function automatic int idx_width(input int taps);
        return (taps > 1) ? $clog2(taps) : 1;
    endfunction

endpackage

// File: rtl/fir_coeff_loader_if.sv
// Valid/ready coefficient stream carrying one coefficient word per beat plus an end-of-set marker.
interface fir_coeff_loader_if
    import fir_pkg::*;
#(
    parameter int COEFF_WIDTH = DEF_COEFF_WIDTH
);

    logic                   coeff_valid;
    logic                   coeff_ready;
    logic [COEFF_WIDTH-1:0] coeff_data;
    logic                   coeff_last;

    modport master (
        output coeff_valid,
        output coeff_data,
        output coeff_last,
        input  coeff_ready
    );

    modport slave (
        input  coeff_valid,
        input  coeff_data,
        input  coeff_last,
        output coeff_ready
    );

endinterface

// File: rtl/fir_coeff_shadow.sv
// Shadow coefficient register file: one indexed write port, full-width parallel read.
module fir_coeff_shadow
    import fir_pkg::*;
#(
    parameter int NUM_TAPS    = DEF_NUM_TAPS,
    parameter int COEFF_WIDTH = DEF_COEFF_WIDTH,
    parameter int IDX_W       = idx_width(NUM_TAPS)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            wr_en,
    input  logic [IDX_W-1:0]                wr_idx,
    input  logic [COEFF_WIDTH-1:0]          wr_data,
    output logic [NUM_TAPS*COEFF_WIDTH-1:0] rd_bus
);

    logic [COEFF_WIDTH-1:0] regs [NUM_TAPS];

    // Out-of-range indices are dropped for tap counts that are not a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NUM_TAPS; k++) begin
                regs[k] <= '0;
            end
        end else if (wr_en && (int'(wr_idx) < NUM_TAPS)) begin
            regs[wr_idx] <= wr_data;
        end
    end

    for (genvar k = 0; k < NUM_TAPS; k++) begin : g_read
        assign rd_bus[k*COEFF_WIDTH +: COEFF_WIDTH] = regs[k];
    end

endmodule

// File: rtl/fir_coeff_loader.sv
// Collects a coefficient set from a valid/ready stream into a shadow register and
// transfers it to the active FIR coefficient bus atomically on a safe-to-swap strobe.
module fir_coeff_loader
    import fir_pkg::*;
#(
    parameter int NUM_TAPS    = DEF_NUM_TAPS,
    parameter int COEFF_WIDTH = DEF_COEFF_WIDTH
) (
    input  logic                            clk,
    input  logic                            rst,
    fir_coeff_loader_if.slave               coeff_stream,
    input  logic                            swap_en,
    output logic [NUM_TAPS*COEFF_WIDTH-1:0] coeffs,
    output logic                            coeffs_updated,
    output logic                            load_error,
    output logic                            busy
);

    localparam int               IDX_W    = idx_width(NUM_TAPS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_TAPS - 1);
    localparam logic [IDX_W-1:0] ONE_IDX  = IDX_W'(1);

    loader_state_t state, state_next;
    logic [IDX_W-1:0] idx, idx_next;
    logic ready_q;
    logic beat;
    logic wr_en;
    logic set_error;
    logic do_swap;
    logic [NUM_TAPS*COEFF_WIDTH-1:0] shadow_bus;

    // Ready comes from a flop so nothing upstream sees a path from coeff_valid.
    assign beat                     = coeff_stream.coeff_valid && ready_q;
    assign coeff_stream.coeff_ready = ready_q;
    assign busy                     = (state != IDLE);

    fir_coeff_shadow #(
        .NUM_TAPS    (NUM_TAPS),
        .COEFF_WIDTH (COEFF_WIDTH),
        .IDX_W       (IDX_W)
    ) u_shadow (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_idx  (idx),
        .wr_data (coeff_stream.coeff_data),
        .rd_bus  (shadow_bus)
    );

    always_comb begin
        state_next = state;
        idx_next   = idx;
        wr_en      = 1'b0;
        set_error  = 1'b0;
        do_swap    = 1'b0;
        case (state)
            IDLE: begin
                if (beat) begin
                    wr_en = 1'b1;
                    if (NUM_TAPS == 1) begin
                        idx_next = '0;
                        if (coeff_stream.coeff_last) begin
                            state_next = PENDING;
                        end else begin
                            set_error  = 1'b1;
                            state_next = DRAIN;
                        end
                    end else if (coeff_stream.coeff_last) begin
                        set_error = 1'b1;
                        idx_next  = '0;
                    end else begin
                        idx_next   = ONE_IDX;
                        state_next = LOAD;
                    end
                end
            end
            LOAD: begin
                if (beat) begin
                    if (idx == LAST_IDX) begin
                        idx_next = '0;
                        if (coeff_stream.coeff_last) begin
                            wr_en      = 1'b1;
                            state_next = PENDING;
                        end else begin
                            // Overlong set: this word would overflow the shadow, so drop it.
                            set_error  = 1'b1;
                            state_next = DRAIN;
                        end
                    end else begin
                        wr_en = 1'b1;
                        if (coeff_stream.coeff_last) begin
                            set_error  = 1'b1;
                            idx_next   = '0;
                            state_next = IDLE;
                        end else begin
                            idx_next = idx + ONE_IDX;
                        end
                    end
                end
            end
            DRAIN: begin
                if (beat && coeff_stream.coeff_last) begin
                    state_next = IDLE;
                end
            end
            PENDING: begin
                if (swap_en) begin
                    do_swap    = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                idx_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            idx            <= '0;
            ready_q        <= 1'b0;
            load_error     <= 1'b0;
            coeffs         <= '0;
            coeffs_updated <= 1'b0;
        end else begin
            state          <= state_next;
            idx            <= idx_next;
            ready_q        <= (state_next != PENDING);
            coeffs_updated <= do_swap;
            if (set_error) begin
                load_error <= 1'b1;
            end
            if (do_swap) begin
                coeffs <= shadow_bus;
            end
        end
    end

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Directed self-checking bench for fir_coeff_loader: nominal, deferred swap, short/long
// sets, asynchronous reset mid-load and while pending, and valid gaps inside a set.
module tb_fir_coeff_loader;
    import fir_pkg::*;

    localparam coeff_bus_t NOM_SET = 128'h0008_0007_0006_0005_0004_0003_0002_0001;
    localparam coeff_bus_t SET_1X  = 128'h0018_0017_0016_0015_0014_0013_0012_0011;
    localparam coeff_bus_t SET_3X  = 128'h0038_0037_0036_0035_0034_0033_0032_0031;
    localparam coeff_bus_t SET_5X  = 128'h0058_0057_0056_0055_0054_0053_0052_0051;

    logic       clk = 1'b0;
    logic       rst;
    logic       swap_en;
    coeff_bus_t coeffs;
    logic       coeffs_updated;
    logic       load_error;
    logic       busy;

    int         checkCount = 0;
    int         passCount  = 0;
    int         updCount   = 0;
    coeff_bus_t prevCoeffs;

    fir_coeff_loader_if #(.COEFF_WIDTH(DEF_COEFF_WIDTH)) cif ();

    fir_coeff_loader #(
        .NUM_TAPS    (DEF_NUM_TAPS),
        .COEFF_WIDTH (DEF_COEFF_WIDTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .coeff_stream   (cif.slave),
        .swap_en        (swap_en),
        .coeffs         (coeffs),
        .coeffs_updated (coeffs_updated),
        .load_error     (load_error),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    endtask

    // One beat, optionally preceded by idle cycles with valid low; returns #1 after the edge.
    task automatic applyStimulus(input logic [15:0] data, input logic last, input int gap);
        repeat (gap) begin
            cif.coeff_valid = 1'b0;
            cif.coeff_data  = 16'hBEEF;
            @(posedge clk);
            #1;
        end
        cif.coeff_valid = 1'b1;
        cif.coeff_data  = data;
        cif.coeff_last  = last;
        @(posedge clk);
        #1;
        cif.coeff_valid = 1'b0;
        cif.coeff_last  = 1'b0;
    endtask

    task automatic sendSet(input logic [15:0] base, input int count, input int lastAt, input int maxGap);
        for (int i = 0; i < count; i++) begin
            applyStimulus(base + 16'(i + 1), (i + 1) == lastAt,
                          (maxGap > 0) ? int'($urandom_range(maxGap, 0)) : 0);
        end
    endtask

    task automatic pulseSwap();
        swap_en = 1'b1;
        @(posedge clk);
        #1;
        swap_en = 1'b0;
    endtask

    // Active coefficients may only move in a cycle flagged by coeffs_updated.
    always @(negedge clk) begin
        if (!rst) begin
            if (coeffs !== prevCoeffs) begin
                checkOutput("coeffs_change_has_pulse", coeffs_updated, 1'b1);
            end
            if (coeffs_updated) begin
                updCount++;
            end
        end
        prevCoeffs = coeffs;
    end

    initial begin
        rst             = 1'b1;
        swap_en         = 1'b0;
        cif.coeff_valid = 1'b0;
        cif.coeff_data  = '0;
        cif.coeff_last  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_coeffs", coeffs, '0);
        checkOutput("reset_updated", coeffs_updated, 1'b0);
        checkOutput("reset_error", load_error, 1'b0);
        checkOutput("reset_busy", busy, 1'b0);
        checkOutput("reset_ready", cif.coeff_ready, 1'b0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("ready_after_reset", cif.coeff_ready, 1'b1);

        $display("[TB] nominal load");
        sendSet(16'h0000, 8, 8, 0);
        checkOutput("nom_pending_ready", cif.coeff_ready, 1'b0);
        checkOutput("nom_pending_busy", busy, 1'b1);
        checkOutput("nom_no_early_swap", coeffs, '0);
        updCount = 0;
        pulseSwap();
        checkOutput("nom_coeffs", coeffs, NOM_SET);
        checkOutput("nom_updated", coeffs_updated, 1'b1);
        checkOutput("nom_error", load_error, 1'b0);
        checkOutput("nom_idle", busy, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("nom_updated_drop", coeffs_updated, 1'b0);
        checkOutput("nom_single_pulse", updCount, 1);

        $display("[TB] deferred swap");
        sendSet(16'h0010, 8, 8, 0);
        cif.coeff_valid = 1'b1;
        cif.coeff_data  = 16'hDEAD;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            checkOutput("defer_ready", cif.coeff_ready, 1'b0);
            checkOutput("defer_busy", busy, 1'b1);
            checkOutput("defer_coeffs", coeffs, NOM_SET);
        end
        cif.coeff_valid = 1'b0;
        pulseSwap();
        checkOutput("defer_coeffs_swapped", coeffs, SET_1X);
        checkOutput("defer_updated", coeffs_updated, 1'b1);

        $display("[TB] long set");
        sendSet(16'h0040, 8, 0, 0);
        checkOutput("long_error", load_error, 1'b1);
        checkOutput("long_drain_busy", busy, 1'b1);
        checkOutput("long_drain_ready", cif.coeff_ready, 1'b1);
        applyStimulus(16'h0049, 1'b0, 0);
        checkOutput("long_drain_ready2", cif.coeff_ready, 1'b1);
        checkOutput("long_drain_busy2", busy, 1'b1);
        applyStimulus(16'h004A, 1'b1, 0);
        checkOutput("long_idle", busy, 1'b0);
        checkOutput("long_coeffs_kept", coeffs, SET_1X);
        pulseSwap();
        pulseSwap();
        checkOutput("long_no_swap", coeffs, SET_1X);
        checkOutput("long_no_pulse", coeffs_updated, 1'b0);

        $display("[TB] reset mid-load");
        sendSet(16'h0020, 4, 0, 0);
        #2 rst = 1'b1;
        #1;
        checkOutput("rstload_coeffs", coeffs, '0);
        checkOutput("rstload_busy", busy, 1'b0);
        checkOutput("rstload_error", load_error, 1'b0);
        checkOutput("rstload_ready", cif.coeff_ready, 1'b0);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;
        sendSet(16'h0050, 8, 8, 0);
        pulseSwap();
        checkOutput("rstload_next_set", coeffs, SET_5X);
        checkOutput("rstload_next_error", load_error, 1'b0);

        $display("[TB] short set");
        sendSet(16'h0020, 5, 5, 0);
        checkOutput("short_error", load_error, 1'b1);
        checkOutput("short_idle", busy, 1'b0);
        checkOutput("short_ready", cif.coeff_ready, 1'b1);
        checkOutput("short_coeffs_kept", coeffs, SET_5X);
        sendSet(16'h0030, 8, 8, 0);
        pulseSwap();
        checkOutput("short_next_set", coeffs, SET_3X);
        checkOutput("short_error_sticky", load_error, 1'b1);

        $display("[TB] reset while pending");
        sendSet(16'h0060, 8, 8, 0);
        checkOutput("rstpend_busy_before", busy, 1'b1);
        #2 rst = 1'b1;
        #1;
        checkOutput("rstpend_coeffs", coeffs, '0);
        checkOutput("rstpend_busy", busy, 1'b0);
        checkOutput("rstpend_error", load_error, 1'b0);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;
        pulseSwap();
        checkOutput("rstpend_set_lost", coeffs, '0);

        $display("[TB] valid gaps inside a set");
        sendSet(16'h0000, 8, 8, 3);
        checkOutput("gap_pending_busy", busy, 1'b1);
        pulseSwap();
        checkOutput("gap_coeffs", coeffs, NOM_SET);
        checkOutput("gap_error", load_error, 1'b0);
        repeat (2) @(posedge clk);
        #1;

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/fir_coeff_loader.md
Name: fir_coeff_loader

Overview:
- Upstream stage of the FIR filters (golden and transposed). It drives their packed, static coefficient bus.
- Accepts coefficients one word per beat on a valid/ready stream and assembles them in a shadow register.
- Transfers the shadow register to the active bus atomically, and only when the datapath signals a safe boundary. The filters therefore never see a partially updated coefficient set.

Parameters:
- NUM_TAPS, 8, number of coefficients (filter taps).
- COEFF_WIDTH, 16, bits per coefficient.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- coeff_valid  in  1  input beat valid.
- coeff_ready  out  1  loader can accept a beat.
- coeff_data  in  COEFF_WIDTH  coefficient word.
- coeff_last  in  1  marks final word of a set.
- swap_en  in  1  safe-to-swap strobe from datapath, e.g. a cycle with no sample valid.
- coeffs  out  NUM_TAPS*COEFF_WIDTH  active coefficients to the FIR. Tap k occupies bits [k*COEFF_WIDTH +: COEFF_WIDTH].
- coeffs_updated  out  1  one-cycle pulse in the cycle coeffs changes.
- load_error  out  1  sticky; a set with wrong length was received.
- busy  out  1  a set is in progress or pending swap.

Behaviour:
- Reset values: coeffs=0, coeffs_updated=0, load_error=0, busy=0, coeff_ready=0 during reset and 1 in the first cycle after reset. The shadow register and index are cleared.
- A beat transfers when coeff_valid && coeff_ready on a rising edge.
- FSM states: IDLE, LOAD, DRAIN, PENDING.
- IDLE (ready=1, busy=0):
  - A beat writes shadow[0] and sets idx=1.
  - If that beat has coeff_last=1 and NUM_TAPS>1, it is an early last: go to IDLE with load_error set.
  - Otherwise go to LOAD.
  - NUM_TAPS==1 with last → PENDING.
- LOAD (ready=1, busy=1): each beat writes shadow[idx] and increments idx.
  - Last word with idx==NUM_TAPS-1 → PENDING.
  - Last word with idx<NUM_TAPS-1 → load_error=1, go to IDLE. The shadow contents are discarded; active coeffs are untouched.
  - Beat at idx==NUM_TAPS-1 without last → load_error=1, go to DRAIN. That word is not written.
- DRAIN (ready=1, busy=1): discards beats until one carrying coeff_last, then goes to IDLE.
- PENDING (ready=0, busy=1):
  - On a cycle with swap_en=1: coeffs <= shadow and coeffs_updated=1, registered so it is visible the cycle after the swap_en edge. Return to IDLE.
  - swap_en in any other state is ignored.
- Latency: last beat accepted at edge N; the earliest coeffs change is at edge N+1 if swap_en=1 in the cycle after N.
- Ready is registered-state based with no combinational path from coeff_valid. Stalls with coeff_valid low hold all state.
- load_error is cleared only by rst.
- Reset mid-load or while PENDING: the shadow set is lost, coeffs=0, FSM returns to IDLE.
- idx width is clog2(NUM_TAPS) (min 1). It never wraps: the overflow case is handled by DRAIN.
- No arithmetic is performed; coefficients pass through bit-exact, and signedness is the filter's concern.

Decomposition:
- Shared package fir_pkg: NUM_TAPS/COEFF_WIDTH defaults, coeff_t (logic [COEFF_WIDTH-1:0]), packed coeff_bus_t, and the FSM state enum loader_state_t.
- One natural sub-module: fir_coeff_shadow, the shadow register file with an indexed write port and a full-width parallel read. The FSM stays in fir_coeff_loader.

Test Plan:
- Nominal load:
  - Stimulus: after reset, send 8 beats 0x0001..0x0008 with last on the 8th, then swap_en=1 one cycle later.
  - Response: coeffs = 0x0008_0007_0006_0005_0004_0003_0002_0001; coeffs_updated pulses exactly once; load_error=0.
- Deferred swap:
  - Stimulus: complete a set, hold swap_en=0 for 20 cycles while presenting a new beat.
  - Response: coeff_ready=0 and busy=1 throughout; coeffs unchanged; the swap occurs the cycle after swap_en rises.
- Short set:
  - Stimulus: 5 beats with last on the 5th.
  - Response: load_error=1; FSM back in IDLE; coeffs keep their previous value; a following correct 8-beat set loads normally.
- Long set:
  - Stimulus: 10 beats with last on the 10th.
  - Response: load_error=1; beats 9–10 are discarded with ready=1; no swap occurs; IDLE afterwards.
- Reset mid-operation:
  - Stimulus: assert rst asynchronously after 4 beats, and separately while PENDING.
  - Response: coeffs=0, busy=0, load_error=0 immediately; the next full set loads correctly.
- Backpressure-free stall:
  - Stimulus: insert random coeff_valid gaps inside a set.
  - Response: same final coeffs as the nominal case.
  - Formal equivalence: a simple model assembles the set in a reference shadow; check coeffs only changes on coeffs_updated.
